// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared funct3 codes, FSM state type and access-size helper
//               for the data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Access size in bytes; the sign/zero bit (funct3[2]) does not affect size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] r_sz;
        case (funct3[1:0])
            2'b00:   r_sz = 4'd1;
            2'b01:   r_sz = 4'd2;
            2'b10:   r_sz = 4'd4;
            default: r_sz = 4'd8;
        endcase
        return r_sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering: store lane enables and data
//               shift, load shift-down with sign/zero extension, error check.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  funct3,
    input  logic                        is_store,
    input  logic [$clog2(XLEN/8)-1:0]   offset,
    input  logic [XLEN-1:0]             wdata,
    input  logic [XLEN-1:0]             raw,
    output logic [XLEN/8-1:0]           byte_en,
    output logic [XLEN-1:0]             wdata_sh,
    output logic [XLEN-1:0]             rdata_ext,
    output logic                        err
);

    localparam int c_nb = XLEN / 8;

    logic [3:0]      w_size;
    logic            w_legal;
    logic            w_misal;
    logic [c_nb-1:0] w_mask;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_keep;
    logic            w_sign;

    always_comb begin
        w_size = size_bytes(funct3);

        case (funct3)
            F3_B, F3_H, F3_W: w_legal = 1'b1;
            F3_BU, F3_HU:     w_legal = !is_store;
            F3_D:             w_legal = (XLEN == 64);
            F3_WU:            w_legal = (XLEN == 64) && !is_store;
            default:          w_legal = 1'b0;
        endcase

        case (w_size)
            4'd2:    w_misal = offset[0];
            4'd4:    w_misal = |offset[1:0];
            4'd8:    w_misal = |offset;
            default: w_misal = 1'b0;
        endcase

        err = !w_legal || w_misal;

        for (int b = 0; b < c_nb; b++) begin
            w_mask[b] = (b < int'(w_size));
        end
        byte_en  = err ? '0 : (w_mask << offset);
        wdata_sh = wdata << {offset, 3'b000};

        w_shifted = raw >> {offset, 3'b000};
        for (int i = 0; i < XLEN; i++) begin
            w_keep[i] = (i < int'(w_size) * 8);
        end

        case (w_size)
            4'd1:    w_sign = w_shifted[7];
            4'd2:    w_sign = w_shifted[15];
            4'd4:    w_sign = w_shifted[31];
            default: w_sign = w_shifted[XLEN-1];
        endcase
        // funct3[2] marks the zero-extending load variants
        if (funct3[2]) begin
            w_sign = 1'b0;
        end

        if (err) begin
            rdata_ext = '0;
        end else begin
            rdata_ext = (w_shifted & w_keep) | (w_sign ? ~w_keep : '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Parametrised data memory with sub-word access, lane writes,
//               error reporting, registered response and post-reset zero sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    localparam int c_nb    = XLEN / 8;
    localparam int c_off_w = $clog2(c_nb);
    localparam int c_idx_w = $clog2(DEPTH);

    state_t               r_state;
    logic [c_idx_w-1:0]   r_cnt;
    logic [XLEN-1:0]      r_mem [DEPTH];
    logic                 r_resp_valid;
    logic [XLEN-1:0]      r_resp_rdata;
    logic                 r_resp_err;

    logic                 w_run;
    logic                 w_accept;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_off_w-1:0]   w_off;
    logic [XLEN-1:0]      w_raw;
    logic [c_nb-1:0]      w_be;
    logic [XLEN-1:0]      w_wdata_sh;
    logic [XLEN-1:0]      w_rdata_ext;
    logic                 w_err;
    logic [c_idx_w-1:0]   w_wr_idx;
    logic [c_nb-1:0]      w_wr_be;
    logic [XLEN-1:0]      w_wr_data;

    assign w_run     = (r_state == ST_RUN);
    assign req_ready = w_run;
    assign init_done = w_run;
    assign w_accept  = req_valid && w_run;

    assign w_idx = req_addr[c_off_w +: c_idx_w];
    assign w_off = req_addr[c_off_w-1:0];
    assign w_raw = r_mem[w_idx];

    // Address bits above the array span are intentionally ignored (wrap).
    generate
        if (ADDR_W > c_off_w + c_idx_w) begin : g_addr_wrap
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^req_addr[ADDR_W-1:c_off_w+c_idx_w];
        end
    endgenerate

    dmem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3    (req_funct3),
        .is_store  (req_we),
        .offset    (w_off),
        .wdata     (req_wdata),
        .raw       (w_raw),
        .byte_en   (w_be),
        .wdata_sh  (w_wdata_sh),
        .rdata_ext (w_rdata_ext),
        .err       (w_err)
    );

    // Single write port shared between the clear sweep and accepted stores.
    always_comb begin
        w_wr_idx  = w_idx;
        w_wr_be   = '0;
        w_wr_data = w_wdata_sh;
        if ((r_state == ST_INIT) && (CLEAR_ON_RESET != 0)) begin
            w_wr_idx  = r_cnt;
            w_wr_be   = '1;
            w_wr_data = '0;
        end else if (w_accept && req_we) begin
            w_wr_be = w_be;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < c_nb; b++) begin
            if (w_wr_be[b]) begin
                r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if ((CLEAR_ON_RESET == 0) || (r_cnt == c_idx_w'(DEPTH - 1))) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_err   <= w_accept && w_err;
            r_resp_rdata <= (w_accept && !req_we) ? w_rdata_ext : '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire
